// File: rtl/seg_serial_tx.sv
// Serialises a packed segment frame MSB first into an external shift-register chain,
// then strobes the chain's storage latch. One frame per accepted start request.
module seg_serial_tx #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned HALF_DIV = 2
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [DATA_W-1:0] seg_data,
    output logic              seg_clk,
    output logic              seg_dat,
    output logic              seg_latch,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CntW = $clog2(DATA_W + 1);
    localparam int unsigned PhW  = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
    localparam logic [PhW-1:0] PhLast = PhW'(HALF_DIV - 1);

    typedef enum logic [2:0] {
        StIdle,
        StShiftLo,
        StShiftHi,
        StLatch,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]   bitcnt_q, bitcnt_d;
    logic [PhW-1:0]    phase_q, phase_d;
    logic              seg_clk_d, seg_dat_d, seg_latch_d, busy_d, done_d;
    logic              phase_last;

    assign phase_last = (phase_q == PhLast);

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        phase_d  = phase_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    shreg_d  = seg_data;
                    bitcnt_d = CntW'(DATA_W);
                    phase_d  = '0;
                    state_d  = StShiftLo;
                end
            end
            StShiftLo: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = StShiftHi;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StShiftHi: begin
                if (phase_last) begin
                    phase_d  = '0;
                    shreg_d  = shreg_q << 1;
                    bitcnt_d = bitcnt_q - 1'b1;
                    state_d  = (bitcnt_q == CntW'(1)) ? StLatch : StShiftLo;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StLatch: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = StDone;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so the external pins never glitch.
    always_comb begin
        seg_clk_d   = (state_d == StShiftHi);
        seg_dat_d   = ((state_d == StShiftLo) || (state_d == StShiftHi)) && shreg_d[DATA_W-1];
        seg_latch_d = (state_d == StLatch);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            phase_q   <= '0;
            seg_clk   <= 1'b0;
            seg_dat   <= 1'b0;
            seg_latch <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bitcnt_q  <= bitcnt_d;
            phase_q   <= phase_d;
            seg_clk   <= seg_clk_d;
            seg_dat   <= seg_dat_d;
            seg_latch <= seg_latch_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_seg_serial_tx.sv
// Bench for seg_serial_tx: two instances (64-bit/HALF_DIV=2 and 8-bit/HALF_DIV=1) checked every
// cycle against a waveform model derived from the frame timing rules.
module tb_seg_serial_tx;

    localparam int W0 = 64;
    localparam int H0 = 2;
    localparam int W1 = 8;
    localparam int H1 = 1;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [63:0] data0 = '0;
    logic [7:0]  data1 = '0;
    logic        seg_clk0, seg_dat0, seg_latch0, busy0, done0;
    logic        seg_clk1, seg_dat1, seg_latch1, busy1, done1;

    always #5 clk = ~clk;

    seg_serial_tx dut0 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start0),
        .seg_data  (data0),
        .seg_clk   (seg_clk0),
        .seg_dat   (seg_dat0),
        .seg_latch (seg_latch0),
        .busy      (busy0),
        .done      (done0)
    );

    seg_serial_tx #(
        .DATA_W   (8),
        .HALF_DIV (1)
    ) dut1 (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start1),
        .seg_data  (data1),
        .seg_clk   (seg_clk1),
        .seg_dat   (seg_dat1),
        .seg_latch (seg_latch1),
        .busy      (busy1),
        .done      (done1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected {seg_clk, seg_dat, seg_latch, busy, done} k cycles after the accepting edge.
    function automatic logic [4:0] ref_outs(input logic act, input int k, input int w,
                                            input int h, input logic [63:0] d);
        if (!act) return 5'b00000;
        if (k < 2 * w * h) return {1'((k / h) % 2), d[w - 1 - k / (2 * h)], 3'b010};
        if (k < 2 * w * h + h) return 5'b00110;
        return 5'b00011;
    endfunction

    // Transaction model: which frame is in flight, when it was accepted and what it carries.
    int          cyc = 0;
    logic        act0 = 1'b0;
    logic        act1 = 1'b0;
    int          e0 = 0;
    int          e1 = 0;
    logic [63:0] md0 = '0;
    logic [63:0] md1 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            act0 <= 1'b0;
            act1 <= 1'b0;
        end else begin
            if (act0 && (cyc - e0 == 2 * W0 * H0 + H0)) act0 <= 1'b0;
            else if (!act0 && start0) begin
                act0 <= 1'b1;
                e0   <= cyc + 1;
                md0  <= data0;
            end
            if (act1 && (cyc - e1 == 2 * W1 * H1 + H1)) act1 <= 1'b0;
            else if (!act1 && start1) begin
                act1 <= 1'b1;
                e1   <= cyc + 1;
                md1  <= {56'd0, data1};
            end
        end
    end

    // Per-cycle waveform check plus serial-capture monitor on seg_clk rising edges.
    logic        pclk0 = 1'b0;
    logic        pclk1 = 1'b0;
    logic [63:0] cap0 = '0;
    logic [7:0]  cap1 = '0;
    int          ncap0 = 0;
    int          ncap1 = 0;
    int          ndone0 = 0;
    int          ndone1 = 0;

    always @(negedge clk) begin
        check_eq("outs0", 64'({seg_clk0, seg_dat0, seg_latch0, busy0, done0}),
                 64'(ref_outs(act0, cyc - e0, W0, H0, md0)));
        check_eq("outs1", 64'({seg_clk1, seg_dat1, seg_latch1, busy1, done1}),
                 64'(ref_outs(act1, cyc - e1, W1, H1, md1)));
        if (!rstn) begin
            cap0  <= '0;
            ncap0 <= 0;
            cap1  <= '0;
            ncap1 <= 0;
        end else begin
            if (seg_clk0 && !pclk0) begin
                cap0  <= {cap0[62:0], seg_dat0};
                ncap0 <= ncap0 + 1;
            end
            if (seg_clk1 && !pclk1) begin
                cap1  <= {cap1[6:0], seg_dat1};
                ncap1 <= ncap1 + 1;
            end
            if (done0) begin
                check_eq("frame0", cap0, md0);
                check_eq("nedge0", 64'(ncap0), 64'(W0));
                cap0   <= '0;
                ncap0  <= 0;
                ndone0 <= ndone0 + 1;
            end
            if (done1) begin
                check_eq("frame1", 64'(cap1), md1);
                check_eq("nedge1", 64'(ncap1), 64'(W1));
                cap1   <= '0;
                ncap1  <= 0;
                ndone1 <= ndone1 + 1;
            end
        end
        pclk0 <= seg_clk0;
        pclk1 <= seg_clk1;
    end

    initial begin
        int t0;
        int n;
        int nd;

        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("idle_outs0", 64'({seg_clk0, seg_dat0, seg_latch0, busy0, done0}), 64'd0);

        // 8-bit instance, directed 8'h81 frame: done 17 edges after acceptance.
        data1  = 8'h81;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        t0 = cyc;
        n = 0;
        while (!done1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("done1_edge", 64'(cyc - t0), 64'd17);
        @(negedge clk);
        check_eq("busy1_fall", 64'(busy1), 64'd0);

        // 64-bit directed frame; data and start disturbed mid-frame must be ignored.
        nd     = ndone0;
        data0  = 64'hC0F9A4B0_99929282;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        t0     = cyc;
        data0  = '1;
        repeat (100) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (!done0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("done0_edge", 64'(cyc - t0), 64'd258);
        @(negedge clk);
        check_eq("busy0_fall", 64'(busy0), 64'd0);
        repeat (40) @(negedge clk);
        check_eq("one_done", 64'(ndone0), 64'(nd + 1));

        // Asynchronous reset at bit 30 of a random frame, then a clean frame.
        nd     = ndone0;
        data0  = {$urandom, $urandom};
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (120) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check_eq("rst_async0", 64'({seg_clk0, seg_dat0, seg_latch0, busy0, done0}), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (2 * W0 * H0 + H0 + 5) @(negedge clk);
        check_eq("no_done_rst", 64'(ndone0), 64'(nd));
        data0  = {$urandom, $urandom};
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        n = 0;
        while (busy0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("post_rst_done", 64'(ndone0), 64'(nd + 1));

        // start held high: back-to-back frames with one idle cycle between them.
        nd     = ndone0;
        start0 = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            data0 = {$urandom, $urandom};
        end
        start0 = 1'b0;
        check_eq("held_dones", 64'(ndone0), 64'(nd + 2));
        n = 0;
        while (busy0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("held_idle", 64'(busy0), 64'd0);

        // Random frames on both instances with random idle gaps.
        for (int i = 0; i < 4; i++) begin
            data0  = {$urandom, $urandom};
            data1  = 8'($urandom);
            start0 = 1'b1;
            start1 = 1'b1;
            @(negedge clk);
            start0 = 1'b0;
            start1 = 1'b0;
            data0  = {$urandom, $urandom};
            n = 0;
            while ((busy0 || busy1) && n < 400) begin
                @(negedge clk);
                n++;
            end
            check_eq("rand_idle", 64'({busy0, busy1}), 64'd0);
            repeat ($urandom_range(0, 5)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
